// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the E stage: fixed-latency busy countdown,
// HI/LO ownership and the MD stall request for the hazard unit.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        md_use,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [31:0]        a_q, b_q;
  logic [1:0]         op_q;
  logic               accept, done;

  // Only IDLE accepts, so stall never depends on anything the hazard unit drives.
  assign accept = (state == IDLE) && start && (op[2] == 1'b0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          cnt_next   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          done       = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    stall = md_use && (busy || accept);
  end

  logic [63:0]        prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic signed [31:0] sa, sb_safe, q_s, r_s;
  logic [31:0]        ub_safe, q_u, r_u;

  assign prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u   = {32'b0, a_q} * {32'b0, b_q};
  assign div_zero = (b_q == 32'b0);
  assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

  // Divisors are forced to 1 in the cases whose result is discarded or
  // overridden, so the divider never sees /0 or the INT_MIN/-1 trap.
  assign sa      = $signed(a_q);
  assign sb_safe = (div_zero || div_ovf) ? 32'sd1 : $signed(b_q);
  assign ub_safe = div_zero ? 32'd1 : b_q;
  assign q_s     = sa / sb_safe;
  assign r_s     = sa % sb_safe;
  assign q_u     = a_q / ub_safe;
  assign r_u     = a_q % ub_safe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op[1:0];
      end else if (state == IDLE && start && op == 3'd4) begin
        hi <= a;
      end else if (state == IDLE && start && op == 3'd5) begin
        lo <= a;
      end
      if (done) begin
        case (op_q)
          2'd0: {hi, lo} <= prod_s;
          2'd1: {hi, lo} <= prod_u;
          2'd2: begin
            if (div_ovf) begin
              hi <= 32'h0;
              lo <= 32'h8000_0000;
            end else if (!div_zero) begin
              hi <= r_s;
              lo <= q_s;
            end
          end
          default: begin
            if (!div_zero) begin
              hi <= r_u;
              lo <= q_u;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scenario bench for muldiv_ctrl with an arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic        md_use = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .md_use(md_use),
    .a(a), .b(b), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: what HI/LO must hold after the op completes.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    logic [63:0] pu;
    int q, r;
    case (o)
      3'd0: begin p = longint'(int'(x)) * longint'(int'(y)); {m_hi, m_lo} = p; end
      3'd1: begin pu = {32'b0, x} * {32'b0, y}; {m_hi, m_lo} = pu; end
      3'd2: begin
        if (y == 0) begin end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin m_hi = 0; m_lo = 32'h8000_0000; end
        else begin q = int'(x) / int'(y); r = int'(x) - q * int'(y); m_hi = r; m_lo = q; end
      end
      3'd3: if (y != 0) begin m_hi = x % y; m_lo = x / y; end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  function automatic int cycles_of(input logic [2:0] o);
    return (o < 2) ? MC : (o < 4) ? DC : 0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One start cycle from IDLE; checks the accept-cycle stall, then scrambles operands.
  task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic md);
    logic exp_stall;
    start = 1'b1; op = o; a = x; b = y; md_use = md;
    exp_stall = md && (o < 4);
    #4;
    n_cmp++;
    if (stall !== exp_stall || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s issue: stall=%b busy=%b required stall=%b busy=0", nm, stall, busy, exp_stall);
    end
    step();
    start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
    model_apply(o, x, y);
  endtask

  task automatic expect_run(input string nm, input int n, input logic md);
    for (int i = 0; i < n; i++) begin
      md_use = md;
      #4;
      n_cmp++;
      if (busy !== 1'b1 || stall !== md) begin
        n_err++;
        $display("FAIL %s busy cycle %0d: busy=%b stall=%b required busy=1 stall=%b", nm, i + 1, busy, stall, md);
      end
      step();
    end
  endtask

  task automatic expect_idle(input string nm);
    md_use = 1'b1;
    #4;
    n_cmp++;
    if (busy !== 1'b0 || stall !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_err++;
      $display("FAIL %s result: busy=%b stall=%b hi=%h lo=%h required busy=0 stall=0 hi=%h lo=%h",
               nm, busy, stall, hi, lo, m_hi, m_lo);
    end else
      $display("ok   %s: hi=%h lo=%h", nm, hi, lo);
    step();
    md_use = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    md_use = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 0 || stall !== 0 || hi !== 0 || lo !== 0) begin
      n_err++;
      $display("FAIL reset state: busy=%b stall=%b hi=%h lo=%h required all 0", busy, stall, hi, lo);
    end else
      $display("ok   reset state");
    md_use = 1'b0;
    m_hi = 0; m_lo = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    step();
  endtask

  task automatic test_mult();
    issue("mult 3*-2", 3'd0, 32'd3, 32'hFFFF_FFFE, 1'b0);
    expect_run("mult 3*-2", MC, 1'b0);
    expect_idle("mult 3*-2");
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_err++;
      $display("FAIL mult const: hi=%h lo=%h required ffffffff fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    issue("divu 17/5", 3'd3, 32'd17, 32'd5, 1'b0);
    expect_run("divu 17/5", DC, 1'b0);
    expect_idle("divu 17/5");
    n_cmp++;
    if (hi !== 32'd2 || lo !== 32'd3) begin
      n_err++;
      $display("FAIL divu const: hi=%h lo=%h required 2 3", hi, lo);
    end
    issue("div -17/5", 3'd2, -32'sd17, 32'd5, 1'b0);
    expect_run("div -17/5", DC, 1'b0);
    expect_idle("div -17/5");
    n_cmp++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL div const: hi=%h lo=%h required fffffffe fffffffd", hi, lo);
    end
    issue("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_run("div ovf", DC, 1'b0);
    expect_idle("div ovf");
  endtask

  task automatic test_stall();
    logic md;
    issue("div stall", 3'd2, 32'd1000, 32'd7, 1'b1);
    for (int i = 0; i < DC; i++) begin
      md = $urandom_range(0, 1);
      expect_run("div stall", 1, md);
    end
    expect_idle("div stall");
  endtask

  task automatic test_divzero();
    issue("mthi", 3'd4, 32'h1234, 32'h0, 1'b1);
    expect_idle("mthi");
    issue("div by 0", 3'd2, 32'd7, 32'd0, 1'b0);
    expect_run("div by 0", DC, 1'b0);
    expect_idle("div by 0");
    n_cmp++;
    if (hi !== 32'h1234) begin
      n_err++;
      $display("FAIL div0 hi: hi=%h required 00001234", hi);
    end
  endtask

  task automatic test_reset_abort();
    issue("multu abort", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    expect_run("multu abort", 2, 1'b0);
    #2;
    reset = 1'b1;
    md_use = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 0 || stall !== 0 || hi !== 0 || lo !== 0) begin
      n_err++;
      $display("FAIL abort: busy=%b stall=%b hi=%h lo=%h required all 0", busy, stall, hi, lo);
    end
    m_hi = 0; m_lo = 0;
    step();
    reset = 1'b0;
    md_use = 1'b0;
    for (int i = 0; i < MC + 2; i++) step();
    expect_idle("after abort");
  endtask

  task automatic test_mtlo();
    issue("mtlo", 3'd5, 32'hDEAD, 32'h0, 1'b1);
    expect_idle("mtlo");
  endtask

  task automatic test_back_to_back();
    issue("mult first", 3'd0, 32'd100, 32'd200, 1'b1);
    md_use = 1'b1;
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    expect_run("mult second ignored", 1, 1'b1);
    start = 1'b0;
    expect_run("mult first", MC - 2, 1'b1);
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
    expect_run("start at completion", 1, 1'b1);
    start = 1'b0; op = 3'd7;
    expect_idle("mult first");
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] x, y;
    logic md;
    for (int k = 0; k < 12; k++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (o >= 2 && o < 4 && $urandom_range(0, 1)) y = y & 32'hFF;
      md = $urandom_range(0, 1);
      issue("random", o, x, y, md);
      if (cycles_of(o) > 0) expect_run("random", cycles_of(o), md);
      expect_idle("random");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_divzero();
    test_reset_abort();
    test_mtlo();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the multiply/divide resource of the 5-stage pipelined MIPS core and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and runs a fixed-latency busy countdown.
- Generates the stall request for the hazard unit whenever an MD-class instruction in E must wait.
- Sits beside the ALU in E; HI/LO feed the mfhi/mflo path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  E-stage op valid this cycle; not gated by stall.
- op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 = no-op.
- md_use  input  1  E-stage instruction is MD-class (any op above, or mfhi/mflo).
- a  input  32  rs operand.
- b  input  32  rt operand.
- busy  output  1  countdown active.
- stall  output  1  combinational: md_use & (busy | start_accepted_this_cycle).
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, counter=0, state=IDLE, latched operands/op cleared.
- States are IDLE and RUN.
- IDLE, start with op 0-3:
  - Latch a, b and op at the edge.
  - Enter RUN with counter = MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- IDLE, start with op 4/5: hi<=a (mthi) or lo<=a (mtlo) at the edge; no busy, no stall.
- IDLE, start with op 6/7: ignored.
- RUN: counter decrements each edge.
  - At the edge where counter==1, HI/LO are written and state returns to IDLE.
  - A start at cycle T produces busy=1 in cycles T+1..T+N, where N is the op's cycle count.
  - Results are visible and busy=0 in cycle T+N+1.
- Start while busy is ignored: the instruction is stalled and reissued by the pipeline.
- A start in the same cycle as the completing edge (counter==1) is also ignored. busy is still 1 that cycle, so stall holds it one more cycle.
- Accepted start (IDLE, op 0-3) with md_use=1: stall=1 in that cycle.
  - This is a decided conservative choice that blocks a back-to-back MD instruction.
  - Since start_accepted is IDLE-only, stall depends only on md_use, busy, start and op: no loop through the hazard unit.
- Arithmetic:
  - mult: {hi,lo} = $signed(a)*$signed(b), 64-bit.
  - multu: unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
- Division by zero: runs the full DIV_CYCLES, busy behaves normally, hi/lo unchanged.
- Signed overflow 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are latched at start. Later changes on a/b during RUN have no effect.
- Reset asserted during RUN: abort immediately, no HI/LO write, all outputs at reset values.
- stall never asserts when md_use=0, even if busy=1.

Test Plan:
- Reset released, start=1 op=0 a=3 b=0xFFFFFFFE -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- op=3 divu a=17 b=5 -> busy 10 cycles; then lo=3, hi=2. Same with op=2 a=-17 b=5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFE.
- During div busy, md_use=1 (mflo) -> stall=1 each busy cycle; md_use=0 -> stall=0; stall drops in the cycle busy falls.
- Set hi=0x1234 via mthi, then div a=7 b=0 -> busy 10 cycles; then hi=0x1234 and lo unchanged.
- Start multu a=0xFFFFFFFF b=2, assert reset at cycle 3 of busy -> hi=lo=0, busy=0 immediately; no later write.
- mtlo a=0xDEAD while IDLE -> lo=0xDEAD next cycle, busy stays 0. Second mult issued while busy -> ignored; only the first result appears.
